// File: rtl/arith_pkg.sv
// Shared arithmetic-block definitions for the iterative signed divider.
//   DEF_DIVIDEND_W / DEF_DIVISOR_W : default operand widths (dividend is twice the divisor)
//   IDLE / CALC / FIX              : divider FSM state encodings
//   DIV_LATENCY                    : clock edges from accept to the out_valid cycle
//   Q_MAX / Q_MIN                  : quotient saturation values on overflow
package arith_pkg;

  localparam int unsigned DEF_DIVIDEND_W = 32;
  localparam int unsigned DEF_DIVISOR_W  = 16;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  localparam int unsigned DIV_LATENCY = 33;

  localparam logic [15:0] Q_MAX = 16'h7FFF;
  localparam logic [15:0] Q_MIN = 16'h8000;

endpackage

// File: rtl/sdiv32by16_seq_if.sv
// Request/response bundle for the iterative signed divider.
//   start, dividend, divisor : request side, driven by the master
//   busy, out_valid          : handshake status, driven by the divider
//   quotient, remainder      : signed results, held until the next completion
//   overflow, div_by_zero    : result flags, held with the results
interface sdiv32by16_seq_if #(
  parameter int unsigned DIVIDEND_W = arith_pkg::DEF_DIVIDEND_W,
  parameter int unsigned DIVISOR_W  = arith_pkg::DEF_DIVISOR_W
);

  logic                  start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  busy;
  logic                  out_valid;
  logic [DIVISOR_W-1:0]  quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  overflow;
  logic                  div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, out_valid, quotient, remainder, overflow, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, out_valid, quotient, remainder, overflow, div_by_zero
  );

endinterface

// File: rtl/udiv_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
//   rem      : current partial remainder (W+1 bits)
//   in_bit   : next dividend bit shifted into the partial remainder
//   dvs      : divisor magnitude
//   rem_next : partial remainder after the trial subtract (restored when it would go negative)
//   q_bit    : quotient bit produced by this iteration
module udiv_step #(
  parameter int unsigned W = 16
) (
  input  logic [W:0]   rem,
  input  logic         in_bit,
  input  logic [W-1:0] dvs,
  output logic [W:0]   rem_next,
  output logic         q_bit
);

  logic [W+1:0] shifted;

  assign shifted  = {rem, in_bit};
  // Trial subtract succeeds exactly when the shifted remainder is not below the divisor.
  assign q_bit    = (shifted >= (W+2)'(dvs));
  assign rem_next = q_bit ? (W+1)'(shifted - (W+2)'(dvs)) : (W+1)'(shifted);

endmodule

// File: rtl/sdiv32by16_seq.sv
// Iterative signed divider: 32-bit dividend by 16-bit divisor, one quotient bit per clock.
// Quotient truncates toward zero; remainder takes the dividend's sign. Fixed 33-edge latency.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, aborts any division in flight
//   bus : slave side of sdiv32by16_seq_if (start/operands in, busy/out_valid/results out)
module sdiv32by16_seq
  import arith_pkg::*;
#(
  parameter int unsigned DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int unsigned DIVISOR_W  = DEF_DIVISOR_W
) (
  input logic              clk,
  input logic              rst,
  sdiv32by16_seq_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DIVIDEND_W);

  logic [1:0]            state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  neg_quot_q;
  logic                  neg_rem_q;
  logic                  dz_q;
  logic [DIVISOR_W-1:0]  dlo_q;
  logic [DIVISOR_W:0]    pr_q;
  logic [DIVIDEND_W-1:0] dq_q;
  logic [DIVISOR_W-1:0]  dm_q;

  logic                  busy_q;
  logic                  valid_q;
  logic [DIVISOR_W-1:0]  quot_q;
  logic [DIVISOR_W-1:0]  rem_q;
  logic                  ov_q;
  logic                  dz_out_q;

  logic [DIVIDEND_W-1:0] dvd_mag;
  logic [DIVISOR_W-1:0]  dvs_mag;
  logic [DIVISOR_W:0]    pr_nxt;
  logic                  q_bit;
  logic [DIVIDEND_W-1:0] q_lim;
  logic [DIVISOR_W-1:0]  uq_lo;
  logic [DIVISOR_W-1:0]  ur;
  logic                  ov_fix;
  logic [DIVISOR_W-1:0]  q_fix;
  logic [DIVISOR_W-1:0]  r_fix;

  // Two's-complement magnitudes; the most negative values map onto themselves as unsigned.
  assign dvd_mag = bus.dividend[DIVIDEND_W-1] ? -bus.dividend : bus.dividend;
  assign dvs_mag = bus.divisor[DIVISOR_W-1] ? -bus.divisor : bus.divisor;

  // dq_q holds the remaining dividend bits at the top and collects quotient bits at the bottom.
  udiv_step #(
    .W (DIVISOR_W)
  ) u_step (
    .rem      (pr_q),
    .in_bit   (dq_q[DIVIDEND_W-1]),
    .dvs      (dm_q),
    .rem_next (pr_nxt),
    .q_bit    (q_bit)
  );

  always_comb begin
    // A negative quotient may reach one more than the positive limit.
    q_lim  = DIVIDEND_W'(Q_MAX) + DIVIDEND_W'(neg_quot_q);
    uq_lo  = dq_q[DIVISOR_W-1:0];
    ur     = pr_q[DIVISOR_W-1:0];
    ov_fix = 1'b0;
    q_fix  = neg_quot_q ? -uq_lo : uq_lo;
    r_fix  = neg_rem_q ? -ur : ur;
    if (dz_q) begin
      q_fix = '0;
      r_fix = dlo_q;
    end else if (dq_q > q_lim) begin
      ov_fix = 1'b1;
      q_fix  = neg_quot_q ? DIVISOR_W'(Q_MIN) : DIVISOR_W'(Q_MAX);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      dlo_q      <= '0;
      pr_q       <= '0;
      dq_q       <= '0;
      dm_q       <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      ov_q       <= 1'b0;
      dz_out_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            neg_quot_q <= bus.dividend[DIVIDEND_W-1] ^ bus.divisor[DIVISOR_W-1];
            neg_rem_q  <= bus.dividend[DIVIDEND_W-1];
            dz_q       <= (bus.divisor == '0);
            dlo_q      <= bus.dividend[DIVISOR_W-1:0];
            dq_q       <= dvd_mag;
            dm_q       <= dvs_mag;
            pr_q       <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= CALC;
          end
        end
        CALC: begin
          pr_q  <= pr_nxt;
          dq_q  <= {dq_q[DIVIDEND_W-2:0], q_bit};
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DIVIDEND_W - 1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          quot_q   <= q_fix;
          rem_q    <= r_fix;
          ov_q     <= ov_fix;
          dz_out_q <= dz_q;
          valid_q  <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.out_valid   = valid_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.overflow    = ov_q;
  assign bus.div_by_zero = dz_out_q;

endmodule

// File: tb/tb_sdiv32by16_seq.sv
// Self-checking bench for sdiv32by16_seq: directed corner cases plus randomized operands,
// compared against a plain-integer reference model. Result vectors are packed as
// {quotient, remainder, overflow, div_by_zero}.
module tb_sdiv32by16_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  sdiv32by16_seq_if bus_if ();

  sdiv32by16_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: signed integer division truncating toward zero, remainder follows dividend.
  function automatic logic [33:0] model(input logic [31:0] dvd, input logic [15:0] dvs);
    longint a, b, q, r;
    a = longint'($signed(dvd));
    b = longint'($signed(dvs));
    if (b == 0) return {16'h0000, dvd[15:0], 2'b01};
    q = a / b;
    r = a % b;
    if (q > 32767)  return {16'h7FFF, r[15:0], 2'b10};
    if (q < -32768) return {16'h8000, r[15:0], 2'b10};
    return {q[15:0], r[15:0], 2'b00};
  endfunction

  function automatic logic [33:0] outs();
    return {bus_if.quotient, bus_if.remainder, bus_if.overflow, bus_if.div_by_zero};
  endfunction

  // Issues one request from a negedge and waits (bounded) for out_valid. poke_at = k pulses a
  // spurious start with junk operands at edge E<k>. Returns at the negedge of the out_valid cycle.
  task automatic do_div(input logic [31:0] dvd, input logic [15:0] dvs, input int poke_at,
                        output logic [33:0] res, output int lat, output int busy_n);
    bus_if.dividend = dvd;
    bus_if.divisor  = dvs;
    bus_if.start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.start    = 1'b0;
    bus_if.dividend = $urandom;
    bus_if.divisor  = 16'($urandom);
    lat    = -1;
    busy_n = 0;
    for (int k = 1; k <= 100; k++) begin
      if (bus_if.busy) busy_n++;
      if (k == poke_at) begin
        bus_if.start    = 1'b1;
        bus_if.dividend = $urandom;
        bus_if.divisor  = 16'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      bus_if.start = 1'b0;
      if (bus_if.out_valid) begin
        lat = k;
        break;
      end
    end
    res = outs();
  endtask

  task automatic test_reset();
    bus_if.start    = 1'b0;
    bus_if.dividend = '0;
    bus_if.divisor  = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus_if.busy, bus_if.out_valid, outs()} !== 36'h0)
      $display("FAIL reset_outputs: got %h want 0", {bus_if.busy, bus_if.out_valid, outs()});
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [33:0] res;
    logic [33:0] exp;
    int lat, busy_n;
    exp = {16'd1000, 16'd0, 2'b00};
    do_div(32'd1000000, 16'd1000, 0, res, lat, busy_n);
    n_checks++;
    if (res !== exp) $display("FAIL basic_result: got %h want %h", res, exp);
    else n_pass++;
    n_checks++;
    if (lat != 33) $display("FAIL basic_latency: got %0d want 33", lat);
    else n_pass++;
    n_checks++;
    if (busy_n != 33) $display("FAIL basic_busy_edges: got %0d want 33", busy_n);
    else n_pass++;
    n_checks++;
    if (bus_if.busy !== 1'b0) $display("FAIL basic_busy_at_valid: got %b want 0", bus_if.busy);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus_if.out_valid, outs()} !== {1'b0, exp})
      $display("FAIL basic_pulse_hold: got %h want %h", {bus_if.out_valid, outs()}, {1'b0, exp});
    else n_pass++;
  endtask

  task automatic test_signs();
    logic [31:0] dvd [6];
    logic [15:0] dvs [6];
    logic [33:0] exp [6];
    logic [33:0] res;
    int lat, busy_n;
    dvd = '{-32'sd7, 32'sd7, -32'sd7, -32'sd1, 32'sd100, -32'sd30000};
    dvs = '{16'd2, -16'sd2, -16'sd2, 16'd5, -16'sd7, 16'd7};
    exp = '{{16'hFFFD, 16'hFFFF, 2'b00}, {16'hFFFD, 16'h0001, 2'b00},
            {16'h0003, 16'hFFFF, 2'b00}, {16'h0000, 16'hFFFF, 2'b00},
            {16'hFFF2, 16'h0002, 2'b00}, {16'hEF43, 16'hFFFB, 2'b00}};
    for (int i = 0; i < 6; i++) begin
      do_div(dvd[i], dvs[i], 0, res, lat, busy_n);
      n_checks++;
      if (res !== exp[i] || lat != 33)
        $display("FAIL signs[%0d]: got %h lat %0d want %h lat 33", i, res, lat, exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_overflow();
    logic [31:0] dvd [4];
    logic [15:0] dvs [4];
    logic [33:0] exp [4];
    logic [33:0] res;
    int lat, busy_n;
    dvd = '{32'h80000000, 32'h00400000, -32'sd32768, 32'sd32769};
    dvs = '{16'hFFFF, 16'h0001, 16'h0001, -16'sd1};
    exp = '{{16'h7FFF, 16'h0000, 2'b10}, {16'h7FFF, 16'h0000, 2'b10},
            {16'h8000, 16'h0000, 2'b00}, {16'h8000, 16'h0000, 2'b10}};
    for (int i = 0; i < 4; i++) begin
      do_div(dvd[i], dvs[i], 0, res, lat, busy_n);
      n_checks++;
      if (res !== exp[i] || lat != 33)
        $display("FAIL overflow[%0d]: got %h lat %0d want %h lat 33", i, res, lat, exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_div_zero();
    logic [33:0] res;
    int lat, busy_n;
    do_div(32'd12345, 16'd0, 0, res, lat, busy_n);
    n_checks++;
    if (res !== {16'h0000, 16'h3039, 2'b01} || lat != 33)
      $display("FAIL div_zero_pos: got %h lat %0d want %h lat 33", res, lat,
               {16'h0000, 16'h3039, 2'b01});
    else n_pass++;
    do_div(-32'sd5, 16'd0, 0, res, lat, busy_n);
    n_checks++;
    if (res !== {16'h0000, 16'hFFFB, 2'b01} || lat != 33)
      $display("FAIL div_zero_neg: got %h lat %0d want %h lat 33", res, lat,
               {16'h0000, 16'hFFFB, 2'b01});
    else n_pass++;
  endtask

  task automatic test_ignore_and_abort();
    logic [33:0] res;
    int lat, busy_n, seen;
    do_div(32'd100000, 16'd7, 5, res, lat, busy_n);
    n_checks++;
    if (res !== {16'd14285, 16'd5, 2'b00} || lat != 33)
      $display("FAIL ignore_start: got %h lat %0d want %h lat 33", res, lat,
               {16'd14285, 16'd5, 2'b00});
    else n_pass++;
    // Start a new request, then reset after edge E9 (before E10).
    bus_if.dividend = 32'd999999;
    bus_if.divisor  = 16'd3;
    bus_if.start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (9) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus_if.busy, bus_if.out_valid, outs()} !== 36'h0)
      $display("FAIL abort_clear: got %h want 0", {bus_if.busy, bus_if.out_valid, outs()});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus_if.out_valid !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0) $display("FAIL abort_no_valid: got %0d pulses want 0", seen);
    else n_pass++;
    do_div(-32'sd1000, 16'd3, 0, res, lat, busy_n);
    n_checks++;
    if (res !== model(-32'sd1000, 16'd3) || lat != 33)
      $display("FAIL after_abort: got %h lat %0d want %h lat 33", res, lat,
               model(-32'sd1000, 16'd3));
    else n_pass++;
  endtask

  // Products of signed 16-bit pairs divided back; consecutive calls start on the out_valid cycle.
  task automatic test_back_to_back();
    logic [33:0] res;
    logic [15:0] a16, b16;
    longint p;
    int lat, busy_n, bad;
    bad = 0;
    for (int a = 0; a <= 65535; a += 1000) begin
      for (int b = 3000; b <= 65535; b += 3000) begin
        a16 = 16'(a);
        b16 = 16'(b);
        p = longint'($signed(a16)) * longint'($signed(b16));
        do_div(p[31:0], b16, 0, res, lat, busy_n);
        n_checks++;
        if (res !== {a16, 16'h0000, 2'b00} || lat != 33) begin
          if (bad < 10)
            $display("FAIL round_trip a=%0d b=%0d: got %h lat %0d want %h lat 33",
                     $signed(a16), $signed(b16), res, lat, {a16, 16'h0000, 2'b00});
          bad++;
        end else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] dvd;
    logic [15:0] dvs;
    logic [33:0] res;
    int lat, busy_n;
    for (int i = 0; i < 60; i++) begin
      dvd = $urandom;
      if (i % 2 == 1) dvd = 32'($signed(dvd[23:0]));
      dvs = 16'($urandom);
      if (i % 4 == 0) dvs = 16'($signed(4'($urandom_range(0, 15))));
      do_div(dvd, dvs, 0, res, lat, busy_n);
      n_checks++;
      if (res !== model(dvd, dvs) || lat != 33)
        $display("FAIL random[%0d] %h/%h: got %h lat %0d want %h lat 33", i, dvd, dvs, res,
                 lat, model(dvd, dvs));
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_overflow();
    test_div_zero();
    test_ignore_and_abort();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
